mem_port_arb: RTL and testbench
===============================

# mem_port_arb

Sequential arbiter that shares the single data memory port between the instruction fetch path and the execute unit's load/store path (the `acs_*` access signals). It accepts one request at a time and drives it onto the memory port with a valid/ready handshake. It then routes the memory response back to the requester that owns the transaction. It sits between IFU/EXU and the memory model or bus bridge, with one transaction outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width; byte-mask width is `DATA_W/8`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: clock; all state updates on the rising edge.
  - `rst_n`, in, 1: asynchronous active-low reset.
- Fetch request:
  - `if_req_valid`, in, 1: fetch request.
  - `if_req_ready`, out, 1: fetch request accepted this cycle.
  - `if_addr`, in, ADDR_W: fetch address; the transaction is always a read of all bytes.
- Fetch response:
  - `if_rsp_valid`, out, 1: fetch data valid, one-cycle pulse.
  - `if_rsp_data`, out, DATA_W: fetch data.
- Load/store request:
  - `ls_req_valid`, in, 1: load/store request (EXU `acs_en`).
  - `ls_req_ready`, out, 1: load/store request accepted.
  - `ls_wr`, in, 1: 1 = store.
  - `ls_bytes`, in, DATA_W/8: byte-enable mask.
  - `ls_addr`, in, ADDR_W: access address.
  - `ls_wdata`, in, DATA_W: store data.
- Load/store response:
  - `ls_rsp_valid`, out, 1: load data, or store acknowledge, one-cycle pulse.
  - `ls_rsp_rdata`, out, DATA_W: load data.
- Memory request:
  - `mem_req_valid`, out, 1: memory request.
  - `mem_req_ready`, in, 1: memory accepts the request.
  - `mem_wr`, out, 1: 1 = write.
  - `mem_bytes`, out, DATA_W/8: byte-enable mask.
  - `mem_addr`, out, ADDR_W: address.
  - `mem_wdata`, out, DATA_W: write data.
- Memory response:
  - `mem_rsp_valid`, in, 1: memory response.
  - `mem_rdata`, in, DATA_W: memory read data.

## Operation
- FSM states: `IDLE`, `REQ`, `RESP`.
- `IDLE`:
  - The grant picker selects a winner among the valid requesters.
  - The winner's `*_req_ready` is 1, combinational, in `IDLE` only.
  - On a handshake, the block latches `wr`, `bytes`, `addr`, `wdata` and `owner`, then moves to `REQ`.
  - A fetch request latches `wr`=0 and `bytes`=all ones.
- `REQ`:
  - `mem_req_valid`=1 and the `mem_*` outputs carry the latched fields.
  - Latched fields are stable until `mem_req_ready`.
  - When `mem_req_ready`=1, the FSM moves to `RESP`.
- `RESP`:
  - On `mem_rsp_valid`, the owner's `*_rsp_valid`=1 in the same cycle, combinational pass-through.
  - `*_rsp_data`/`*_rsp_rdata` = `mem_rdata` in that cycle; `RESP`→`IDLE` on that edge.
  - The response also pulses for stores; `ls_rsp_rdata` is don't-care then.
- Default arbitration: fixed priority, load/store over fetch.
- Requester inputs are ignored outside an `IDLE` handshake, so they may change freely.
- `mem_rsp_valid` outside `RESP` is ignored.
- The non-owner's `*_rsp_valid` is always 0.
- Request fields are passed through unmodified; no address or mask checking.

## Timing
- Reset values:
  - State is `IDLE` and `owner` is fetch.
  - All latched fields are 0, so `mem_req_valid`, `mem_wr`, `mem_bytes`, `mem_addr` and `mem_wdata` are 0.
  - Both `*_rsp_valid` are 0.
  - Both `*_req_ready` are 0 while `rst_n`=0.
- Minimum latency:
  - Handshake in cycle N, then `mem_req_valid` in N+1.
  - With `mem_req_ready`=1 in N+1, the response can arrive in N+2, and `*_rsp_valid` pulses in N+2.
  - The next handshake can occur in N+3.
- Throughput: at most one transaction per 3 cycles.
- `mem_req_ready` and `mem_rsp_valid` may be held low indefinitely; the block waits with no timeout.
- Simultaneous `if_req_valid` and `ls_req_valid` in `IDLE`: exactly one ready is asserted, never both.
- Reset asserted mid-transaction:
  - The in-flight transaction is dropped and the block is in `IDLE` immediately.
  - No response is delivered, and any late `mem_rsp_valid` is ignored.

## Configuration
- `MEM_ARB_RR_EN`:
  - Defined: round-robin arbitration. A 1-bit `last_grant` register, reset to fetch, updates on each handshake. When both requesters are valid, the one not granted last wins.
  - Undefined: fixed load/store priority, and no `last_grant` register is built.

## Structure
- Package `mem_arb_pkg` holds:
  - `mem_arb_state_t` enum: `IDLE`, `REQ`, `RESP`.
  - `mem_arb_owner_t`: `OWN_IF`=0, `OWN_LS`=1.
  - The default widths.
- Sub-module `mem_arb_pick`:
  - Combinational grant selection from the two valid inputs plus `last_grant`.
  - Output is a one-hot grant.
- Top module holds the FSM, the request latch and the response routing.

## Test plan
- Lone fetch: `if_addr`=0x8000_0000, memory always ready, `mem_rdata`=0x13 → `mem_addr`=0x8000_0000, `mem_bytes`=0xFF, `mem_wr`=0, `if_rsp_valid` pulses at N+2 with 0x13, `ls_rsp_valid` stays 0.
- Store: `ls_wr`=1, `ls_bytes`=0x0F, `ls_addr`=0x100, `ls_wdata`=0xDEAD_BEEF → the `mem_*` outputs carry exactly these values, `ls_rsp_valid` pulses once.
- Both requesters valid every cycle for 6 transactions:
  - Macro undefined: 6 load/store grants, 0 fetch grants.
  - `MEM_ARB_RR_EN` defined: grants alternate LS, IF, LS, IF, …
- Backpressure: `mem_req_ready` low for 5 cycles, then `mem_rsp_valid` delayed 3 cycles → `mem_*` stable throughout, both `*_req_ready`=0, one response pulse.
- Stray `mem_rsp_valid` in `IDLE` and `REQ` → no `*_rsp_valid`.
- `rst_n` low while in `RESP` → immediate `IDLE`, all outputs 0; after release, a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/EXU memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 64;
  localparam int MEM_ARB_DATA_W = 64;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way combinational grant picker with one-hot output. MEM_ARB_RR_EN selects
// round-robin on contention; otherwise load/store always beats fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_if_vld,
  input  logic       i_ls_vld,
`ifdef MEM_ARB_RR_EN
  input  logic       i_last_grant,
`endif
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = '0;
`ifdef MEM_ARB_RR_EN
    if (i_if_vld && i_ls_vld) begin
      if (i_last_grant == OWN_LS) o_grant[GNT_IF] = 1'b1;
      else                        o_grant[GNT_LS] = 1'b1;
    end else if (i_ls_vld) begin
      o_grant[GNT_LS] = 1'b1;
    end else if (i_if_vld) begin
      o_grant[GNT_IF] = 1'b1;
    end
`else
    if (i_ls_vld)      o_grant[GNT_LS] = 1'b1;
    else if (i_if_vld) o_grant[GNT_IF] = 1'b1;
`endif
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one memory port between fetch and load/store, one transaction in flight;
// request at N+1 after handshake, response passes through combinationally. Optional MEM_ARB_RR_EN.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int DATA_W = MEM_ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_wr,
  input  logic [DATA_W/8-1:0] ls_bytes,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_bytes,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  mem_arb_state_t      r_state;
  mem_arb_owner_t      r_owner;
  logic                r_req_vld;
  logic                r_wr;
  logic [DATA_W/8-1:0] r_bytes;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
`ifdef MEM_ARB_RR_EN
  mem_arb_owner_t      r_last_grant;
`endif

  logic [1:0] w_grant;
  logic       w_idle;
  logic       w_if_hs;
  logic       w_ls_hs;
  logic       w_rsp;

  mem_arb_pick u_pick (
    .i_if_vld     (if_req_valid),
    .i_ls_vld     (ls_req_valid),
`ifdef MEM_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_grant      (w_grant)
  );

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign w_idle  = rst_n && (r_state == IDLE);
  assign w_if_hs = w_idle && w_grant[GNT_IF] && if_req_valid;
  assign w_ls_hs = w_idle && w_grant[GNT_LS] && ls_req_valid;
  assign w_rsp   = (r_state == RESP) && mem_rsp_valid;

  assign if_req_ready = w_idle && w_grant[GNT_IF];
  assign ls_req_ready = w_idle && w_grant[GNT_LS];

  assign if_rsp_valid = w_rsp && (r_owner == OWN_IF);
  assign ls_rsp_valid = w_rsp && (r_owner == OWN_LS);
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign ls_rsp_rdata = ls_rsp_valid ? mem_rdata : '0;

  assign mem_req_valid = r_req_vld;
  assign mem_wr        = r_wr;
  assign mem_bytes     = r_bytes;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      r_req_vld <= 1'b0;
      r_wr      <= 1'b0;
      r_bytes   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_grant <= OWN_IF;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ls_hs) begin
            r_state   <= REQ;
            r_req_vld <= 1'b1;
            r_owner   <= OWN_LS;
            r_wr      <= ls_wr;
            r_bytes   <= ls_bytes;
            r_addr    <= ls_addr;
            r_wdata   <= ls_wdata;
`ifdef MEM_ARB_RR_EN
            r_last_grant <= OWN_LS;
`endif
          end else if (w_if_hs) begin
            r_state   <= REQ;
            r_req_vld <= 1'b1;
            r_owner   <= OWN_IF;
            r_wr      <= 1'b0;
            r_bytes   <= '1;
            r_addr    <= if_addr;
            r_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_grant <= OWN_IF;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_state   <= RESP;
            r_req_vld <= 1'b0;
          end
        end
        RESP: begin
          if (mem_rsp_valid) r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_req_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: vector table plus hand-written corner sequences.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_addr;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_wr;
  logic [7:0]  ls_bytes;
  logic [63:0] ls_addr, ls_wdata;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wr;
  logic [7:0]  mem_bytes;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_wr         (ls_wr),
    .ls_bytes      (ls_bytes),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_rdata  (ls_rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wr        (mem_wr),
    .mem_bytes     (mem_bytes),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  typedef struct {
    logic        if_v;
    logic [63:0] if_a;
    logic        ls_v;
    logic        ls_w;
    logic [7:0]  ls_b;
    logic [63:0] ls_a;
    logic [63:0] ls_d;
    logic [63:0] rdata;
    logic        e_ls;     // expected owner: 1 = load/store
    logic        e_wr;
    logic [7:0]  e_bytes;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic        chk_data; // response data is meaningful
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1 with the memory side idle; memory accepts immediately.
  task automatic run_vec(input vec_t v, input string nm);
    if_req_valid = v.if_v; if_addr = v.if_a;
    ls_req_valid = v.ls_v; ls_wr = v.ls_w; ls_bytes = v.ls_b;
    ls_addr = v.ls_a; ls_wdata = v.ls_d;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_if_rdy"}, if_req_ready, !v.e_ls);
    chk({nm, "_ls_rdy"}, ls_req_ready, v.e_ls);
    @(posedge clk); #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    ls_addr = 64'hBAD0; ls_wdata = 64'hBAD1; ls_bytes = 8'h5A; if_addr = 64'hBAD2;
    @(negedge clk);
    chk({nm, "_req_vld"}, mem_req_valid, 1'b1);
    chk({nm, "_wr"}, mem_wr, v.e_wr);
    chk({nm, "_bytes"}, mem_bytes, v.e_bytes);
    chk({nm, "_addr"}, mem_addr, v.e_addr);
    chk({nm, "_wdata"}, mem_wdata, v.e_wdata);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rdata = v.rdata;
    @(negedge clk);
    chk({nm, "_if_rsp"}, if_rsp_valid, !v.e_ls);
    chk({nm, "_ls_rsp"}, ls_rsp_valid, v.e_ls);
    if (v.chk_data) begin
      if (v.e_ls) chk({nm, "_ls_data"}, ls_rsp_rdata, v.rdata);
      else        chk({nm, "_if_data"}, if_rsp_data, v.rdata);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_done_vld"}, mem_req_valid, 1'b0);
    chk({nm, "_no_2nd_pulse"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   n_ls;
    logic e_ls;

    //           if_v if_a             ls_v ls_w ls_b   ls_a      ls_d            rdata                  e_ls e_wr e_bytes e_addr          e_wdata         chk_data
    vecs[0] = '{1'b1, 64'h8000_0000, 1'b0, 1'b0, 8'h00, 64'h0,    64'h0,          64'h13,                1'b0, 1'b0, 8'hFF, 64'h8000_0000, 64'h0,          1'b1};
    vecs[1] = '{1'b0, 64'h0,         1'b1, 1'b1, 8'h0F, 64'h100,  64'hDEAD_BEEF,  64'h0,                 1'b1, 1'b1, 8'h0F, 64'h100,       64'hDEAD_BEEF,  1'b0};
    vecs[2] = '{1'b0, 64'h0,         1'b1, 1'b0, 8'hF0, 64'h2000, 64'h55,         64'hCAFE_F00D,         1'b1, 1'b0, 8'hF0, 64'h2000,      64'h55,         1'b1};
    vecs[3] = '{1'b1, 64'h1234,      1'b0, 1'b1, 8'h01, 64'h0,    64'h0,          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 8'hFF, 64'h1234,      64'h0,          1'b1};

    // Reset state, with both requesters and a stray response asserted.
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h40;
    ls_req_valid = 1'b1; ls_wr = 1'b1; ls_bytes = 8'hFF; ls_addr = 64'h80; ls_wdata = 64'h1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'h77;
    #12;
    chk("rst_if_rdy", if_req_ready, 1'b0);
    chk("rst_ls_rdy", ls_req_ready, 1'b0);
    chk("rst_req_vld", mem_req_valid, 1'b0);
    chk("rst_fields", {mem_wr, mem_bytes, mem_addr, mem_wdata}, '0);
    chk("rst_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_rsp_valid = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Contention: both requesters valid for 6 back-to-back transactions.
    n_ls = 0;
    if_req_valid = 1'b1; if_addr = 64'h1000;
    ls_req_valid = 1'b1; ls_wr = 1'b0; ls_bytes = 8'hFF; ls_addr = 64'h2000; ls_wdata = 64'h0;
    mem_req_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
`ifdef MEM_ARB_RR_EN
      e_ls = (t % 2 == 0);
`else
      e_ls = 1'b1;
`endif
      @(negedge clk);
      chk($sformatf("both%0d_onehot", t), {if_req_ready, ls_req_ready}, {!e_ls, e_ls});
      if (ls_req_ready) n_ls++;
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("both%0d_addr", t), mem_addr, e_ls ? 64'h2000 : 64'h1000);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1; mem_rdata = 64'(t + 100);
      @(negedge clk);
      chk($sformatf("both%0d_rsp", t), {if_rsp_valid, ls_rsp_valid}, {!e_ls, e_ls});
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("both_ls_count", n_ls, 3);
`else
    chk("both_ls_count", n_ls, 6);
`endif
    @(posedge clk); #1;

    // Backpressure: request stalled 5 cycles, response delayed 3 cycles.
    ls_req_valid = 1'b1; ls_wr = 1'b1; ls_bytes = 8'h3C; ls_addr = 64'h40; ls_wdata = 64'h1122;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    if_req_valid = 1'b1; ls_addr = 64'h999; ls_wdata = 64'h0; ls_bytes = 8'h00; ls_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_req%0d_vld", i), mem_req_valid, 1'b1);
      chk($sformatf("bp_req%0d_fields", i), {mem_wr, mem_bytes, mem_addr[15:0], mem_wdata[15:0]},
          {1'b1, 8'h3C, 16'h0040, 16'h1122});
      chk($sformatf("bp_req%0d_rdy", i), {if_req_ready, ls_req_ready}, 2'b00);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_rsp%0d_wait", i), {if_rsp_valid, ls_rsp_valid, if_req_ready, ls_req_ready, mem_req_valid}, 5'b0);
      chk($sformatf("bp_rsp%0d_stable", i), mem_addr, 64'h40);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b1;
    #1;
    chk("bp_rsp_pulse", {if_rsp_valid, ls_rsp_valid}, 2'b01);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk);
    chk("bp_single_pulse", {if_rsp_valid, ls_rsp_valid, mem_req_valid}, 3'b000);
    @(posedge clk); #1;

    // Stray responses in IDLE and REQ.
    mem_rsp_valid = 1'b1; mem_rdata = 64'hEE;
    @(negedge clk);
    chk("stray_idle", {if_rsp_valid, ls_rsp_valid}, 2'b00);
    if_req_valid = 1'b1; if_addr = 64'h500; mem_req_ready = 1'b0;
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("stray_req", {if_rsp_valid, ls_rsp_valid}, 2'b00);
    chk("stray_req_vld", mem_req_valid, 1'b1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("stray_resp_wait", {if_rsp_valid, mem_req_valid}, 2'b00);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h5A;
    #1;
    chk("stray_final_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b10);
    chk("stray_final_data", if_rsp_data, 64'h5A);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;

    // Reset while in RESP.
    if_req_valid = 1'b1; if_addr = 64'hABC0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; if_req_valid = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'h99;
    #1;
    chk("mid_rst_rsp", {if_rsp_valid, ls_rsp_valid, if_rsp_data}, '0);
    chk("mid_rst_rdy", {if_req_ready, ls_req_ready}, 2'b00);
    chk("mid_rst_mem", {mem_req_valid, mem_wr, mem_bytes, mem_addr, mem_wdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; if_req_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_ignored", {if_rsp_valid, ls_rsp_valid, mem_req_valid}, 3'b000);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
